// File: rtl/aes_round_linear_if.sv
// Transfer bundle for the AES linear round stage: one state/key/mode in, one state out.
// master drives the request side, slave is the round datapath.
interface aes_round_linear_if;
   logic         in_valid;
   logic         inv;
   logic [1:0]   op;
   logic [127:0] state_in;
   logic [127:0] round_key;
   logic         out_valid;
   logic [127:0] state_out;

   modport master (
      output in_valid, inv, op, state_in, round_key,
      input  out_valid, state_out
   );

   modport slave (
      input  in_valid, inv, op, state_in, round_key,
      output out_valid, state_out
   );
endinterface

// File: rtl/aes_round_linear.sv
// AES-128 linear round steps (ShiftRows/MixColumns/AddRoundKey and inverses).
// All transforms are combinational; the result is registered one cycle after acceptance.
module aes_round_linear (
   input  logic                clk,
   input  logic                rst,
   aes_round_linear_if.slave   bus
);

   typedef enum logic [1:0] {
      OP_FULL  = 2'b00,
      OP_FINAL = 2'b01,
      OP_KEY   = 2'b10,
      OP_PASS  = 2'b11
   } op_t;

   function automatic logic [7:0] xt(input logic [7:0] x);
      xt = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] x);
      mul3 = xt(x) ^ x;
   endfunction

   // Inverse-matrix constants built from x*8, x*4, x*2 and x.
   function automatic logic [7:0] mul9(input logic [7:0] x);
      mul9 = xt(xt(xt(x))) ^ x;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] x);
      mulb = xt(xt(xt(x))) ^ xt(x) ^ x;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] x);
      muld = xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] x);
      mule = xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
   endfunction

   logic [127:0] ark;
   logic [127:0] sr;
   logic [127:0] mc;
   logic [127:0] imc;
   logic [127:0] isr_mix;
   logic [127:0] isr_plain;
   logic [127:0] result;

   logic [127:0] state_q, state_d;
   logic         valid_q, valid_d;

   assign ark = bus.state_in ^ bus.round_key;

   // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_shift
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC_L = ROW + 4 * ((COL + ROW) % 4);
         localparam int SRC_R = ROW + 4 * ((COL - ROW + 4) % 4);
         assign sr[127-8*gi -: 8]        = bus.state_in[127-8*SRC_L -: 8];
         assign isr_mix[127-8*gi -: 8]   = imc[127-8*SRC_R -: 8];
         assign isr_plain[127-8*gi -: 8] = ark[127-8*SRC_R -: 8];
      end

      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] a0, a1, a2, a3;
         logic [7:0] d0, d1, d2, d3;
         assign a0 = sr[127-32*gi -: 8];
         assign a1 = sr[119-32*gi -: 8];
         assign a2 = sr[111-32*gi -: 8];
         assign a3 = sr[103-32*gi -: 8];
         assign mc[127-32*gi -: 8] = xt(a0) ^ mul3(a1) ^ a2 ^ a3;
         assign mc[119-32*gi -: 8] = a0 ^ xt(a1) ^ mul3(a2) ^ a3;
         assign mc[111-32*gi -: 8] = a0 ^ a1 ^ xt(a2) ^ mul3(a3);
         assign mc[103-32*gi -: 8] = mul3(a0) ^ a1 ^ a2 ^ xt(a3);

         // Decrypt mixes the key-added state before un-shifting.
         assign d0 = ark[127-32*gi -: 8];
         assign d1 = ark[119-32*gi -: 8];
         assign d2 = ark[111-32*gi -: 8];
         assign d3 = ark[103-32*gi -: 8];
         assign imc[127-32*gi -: 8] = mule(d0) ^ mulb(d1) ^ muld(d2) ^ mul9(d3);
         assign imc[119-32*gi -: 8] = mul9(d0) ^ mule(d1) ^ mulb(d2) ^ muld(d3);
         assign imc[111-32*gi -: 8] = muld(d0) ^ mul9(d1) ^ mule(d2) ^ mulb(d3);
         assign imc[103-32*gi -: 8] = mulb(d0) ^ muld(d1) ^ mul9(d2) ^ mule(d3);
      end
   endgenerate

   always_comb begin
      result = bus.state_in;
      case (op_t'(bus.op))
         OP_FULL:  result = bus.inv ? isr_mix : (mc ^ bus.round_key);
         OP_FINAL: result = bus.inv ? isr_plain : (sr ^ bus.round_key);
         OP_KEY:   result = ark;
         OP_PASS:  result = bus.state_in;
         default:  result = bus.state_in;
      endcase
   end

   always_comb begin
      valid_d = bus.in_valid;
      state_d = state_q;
      if (bus.in_valid) begin
         state_d = result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   assign bus.state_out = state_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_aes_round_linear.sv
// Randomized and directed check of aes_round_linear against a byte-matrix reference model.
module tb_aes_round_linear;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   txn;
   logic [127:0] exp_state;

   aes_round_linear_if bus ();

   aes_round_linear dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Generic GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] getb(input logic [127:0] s, input int r, input int c);
      return s[127-8*(r+4*c) -: 8];
   endfunction

   // dir=+1: rotate row r left by r; dir=-1: rotate right.
   function automatic logic [127:0] shift(input logic [127:0] s, input int dir);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = getb(s, r, (c + dir*r + 4) % 4);
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
      logic [7:0]   base [4];
      logic [7:0]   acc;
      logic [127:0] o;
      if (inverse) begin
         base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
      end else begin
         base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      end
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(base[(j - r + 4) % 4], getb(s, j, c));
            o[127-8*(r+4*c) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                          input logic [1:0] op, input logic inv);
      case (op)
         2'b00:   return inv ? shift(mix(s ^ k, 1'b1), -1) : (mix(shift(s, 1), 1'b0) ^ k);
         2'b01:   return inv ? shift(s ^ k, -1) : (shift(s, 1) ^ k);
         2'b10:   return s ^ k;
         default: return s;
      endcase
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step(input logic v, input logic i, input logic [1:0] o,
                       input logic [127:0] s, input logic [127:0] k, input string tag);
      @(negedge clk);
      bus.in_valid  = v;
      bus.inv       = i;
      bus.op        = o;
      bus.state_in  = s;
      bus.round_key = k;
      @(posedge clk);
      #1;
      if (v) exp_state = model(s, k, o, i);
      check({tag, "_valid"}, {127'd0, bus.out_valid}, {127'd0, v});
      check({tag, "_state"}, bus.state_out, exp_state);
      txn++;
      $display("txn %0d %s v=%0b inv=%0b op=%0d out=%h", txn, tag, v, i, o, bus.state_out);
   endtask

   initial begin
      total = 0;
      bad = 0;
      txn = 0;
      exp_state = '0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.inv       = 1'b0;
      bus.op        = 2'b00;
      bus.state_in  = '0;
      bus.round_key = '0;

      // Reset held with live random traffic.
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.inv       = 1'($urandom);
         bus.op        = 2'($urandom);
         bus.state_in  = rnd128();
         bus.round_key = rnd128();
         @(posedge clk);
         #1;
         check("rst_state", bus.state_out, '0);
         check("rst_valid", {127'd0, bus.out_valid}, '0);
      end
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 1'b0, 2'b10, 128'h00112233445566778899aabbccddeeff,
           128'h000102030405060708090a0b0c0d0e0f, "keyadd");
      check("keyadd_vec", bus.state_out, 128'h00102030405060708090a0b0c0d0e0f0);

      step(1'b1, 1'b0, 2'b01, 128'h000102030405060708090a0b0c0d0e0f, '0, "final");
      check("final_vec", bus.state_out, 128'h00050a0f04090e03080d02070c01060b);

      step(1'b1, 1'b0, 2'b00, {4{32'hdb135345}}, '0, "mixcol");
      check("mixcol_vec", bus.state_out, {4{32'h8e4da1bc}});

      step(1'b1, 1'b0, 2'b00, 128'h63cab7040953d051cd60e0e7ba70e18c,
           128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "full");
      check("full_vec", bus.state_out, 128'h89d810e8855ace682d1843d8cb128fe4);

      step(1'b1, 1'b1, 2'b00, 128'h89d810e8855ace682d1843d8cb128fe4,
           128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "invfull");
      check("invfull_vec", bus.state_out, 128'h63cab7040953d051cd60e0e7ba70e18c);

      step(1'b0, 1'b0, 2'b10, rnd128(), rnd128(), "idle");
      check("idle_hold", bus.state_out, 128'h63cab7040953d051cd60e0e7ba70e18c);

      step(1'b1, 1'b1, 2'b11, 128'hfedcba98765432100123456789abcdef, rnd128(), "pass");

      // Asynchronous reset between edges clears outputs at once.
      #2;
      rst = 1'b1;
      #1;
      check("async_state", bus.state_out, '0);
      check("async_valid", {127'd0, bus.out_valid}, '0);
      exp_state = '0;
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 1'b0, 2'b10, rnd128(), rnd128(), "post_rst");

      for (int n = 0; n < 150; n++)
         step(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), rnd128(), rnd128(), "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
